pipe_mux_param: RTL and testbench

Parametrised, pipelined W-bit N-to-1 multiplexer with a valid/ready stream interface. It generalises the flat combinational 1-bit 128-to-1 mux: arbitrary channel width and power-of-two input count, a radix-4 reduction tree registered at every level, and full back-pressure support. It sits on wide datapath select points where a single-cycle 128:1 (or larger) mux does not close timing.

---
 rtl/pipe_mux_pkg.sv | 30 +++
 rtl/pipe_mux_level.sv | 46 ++++
 rtl/pipe_mux_param.sv | 94 +++++++++
 tb/tb_pipe_mux_param.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mux_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined radix-4 mux tree.
// Levels consume two select bits each; an odd select width leaves a final 2:1 level.
package pipe_mux_pkg;

    localparam int RADIX      = 4;
    localparam int RADIX_BITS = $clog2(RADIX);

    // Number of registered reduction levels for an n-input tree.
    function automatic int num_levels(input int n);
        return ($clog2(n) + RADIX_BITS - 1) / RADIX_BITS;
    endfunction

    // Select bits consumed by level k (RADIX_BITS, or fewer at the last level).
    function automatic int level_sel_bits(input int n, input int k);
        int rem;
        rem = $clog2(n) - k * RADIX_BITS;
        return (rem < RADIX_BITS) ? rem : RADIX_BITS;
    endfunction

    // Width of the partial vector held in the register of level k.
    function automatic int part_width(input int n, input int w, input int k);
        int used;
        used = 0;
        for (int j = 0; j <= k; j++) begin
            used += level_sel_bits(n, j);
        end
        return (n >> used) * w;
    endfunction

endpackage

// File: rtl/pipe_mux_level.sv
// One registered reduction level: picks one partial out of every group of
// 2**p_selbits using the consumed select bits, then holds it under adv control.
module pipe_mux_level
    import pipe_mux_pkg::*;
#(
    parameter int p_nparts  = 4,
    parameter int p_nbits   = 1,
    parameter int p_selbits = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         adv,
    input  logic                                         up_val,
    input  logic [p_nparts*p_nbits-1:0]                  up_data,
    input  logic [p_selbits-1:0]                         up_sel,
    output logic                                         val,
    output logic [(p_nparts>>p_selbits)*p_nbits-1:0]     data
);

    localparam int NOUT = p_nparts >> p_selbits;
    localparam int GRP  = 1 << p_selbits;

    logic [NOUT*p_nbits-1:0] reduced;

    always_comb begin
        reduced = '0;
        for (int g = 0; g < NOUT; g++) begin
            reduced[g*p_nbits +: p_nbits] =
                up_data[(g*GRP + int'(up_sel))*p_nbits +: p_nbits];
        end
    end

    // Data only moves with a valid transfer; an empty slot keeps its old bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val  <= 1'b0;
            data <= '0;
        end else if (adv) begin
            val <= up_val;
            if (up_val) begin
                data <= reduced;
            end
        end
    end

endmodule

// File: rtl/pipe_mux_param.sv
// Pipelined W-bit N:1 mux with valid/ready stream ports, one register per tree level.
// Handshake: a transfer happens on a port when its valid and ready are both high at
// a rising edge; ready never depends on valid, so there is no path in_val -> in_rdy.
module pipe_mux_param
    import pipe_mux_pkg::*;
#(
    parameter int p_nbits   = 1,
    parameter int p_ninputs = 128
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [p_ninputs*p_nbits-1:0]   in_,
    input  logic [$clog2(p_ninputs)-1:0]   sel,
    input  logic                           in_val,
    output logic                           in_rdy,
    output logic [p_nbits-1:0]             out,
    output logic                           out_val,
    input  logic                           out_rdy
);

    localparam int W = p_nbits;
    localparam int N = p_ninputs;
    localparam int S = $clog2(N);
    localparam int L = num_levels(N);

    logic [L:0]   adv;
    logic [L-1:0] vals;

    // A level may load when it is empty or its contents leave this cycle.
    always_comb begin
        adv    = '0;
        adv[L] = out_rdy;
        for (int k = L - 1; k >= 0; k--) begin
            adv[k] = !vals[k] || adv[k+1];
        end
    end

    assign in_rdy = reset && adv[0];

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int SIN = S - k * RADIX_BITS;
        localparam int C   = level_sel_bits(N, k);
        localparam int NIN = N >> (k * RADIX_BITS);
        localparam int PW  = part_width(N, W, k);

        logic [SIN-1:0]   sel_in;
        logic [NIN*W-1:0] data_in;
        logic             val_in;
        logic [PW-1:0]    data_q;

        if (k == 0) begin : g_src
            assign sel_in  = sel;
            assign data_in = in_;
            assign val_in  = in_val;
        end else begin : g_src
            assign sel_in  = g_lvl[k-1].g_sel.q;
            assign data_in = g_lvl[k-1].data_q;
            assign val_in  = vals[k-1];
        end

        pipe_mux_level #(
            .p_nparts  (NIN),
            .p_nbits   (W),
            .p_selbits (C)
        ) u_level (
            .clk     (clk),
            .reset   (reset),
            .adv     (adv[k]),
            .up_val  (val_in),
            .up_data (data_in),
            .up_sel  (sel_in[C-1:0]),
            .val     (vals[k]),
            .data    (data_q)
        );

        // Only the not-yet-consumed select bits travel with the partials.
        if (SIN > C) begin : g_sel
            logic [SIN-C-1:0] q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else if (adv[k] && val_in) begin
                    q <= sel_in[SIN-1:C];
                end
            end
        end

        if (k == L - 1) begin : g_out
            assign out     = data_q;
            assign out_val = vals[k];
        end
    end

endmodule

// File: tb/tb_pipe_mux_param.sv
// Directed and random checks of pipe_mux_param at defaults, plus W=8 N=16 / N=32 trees.
module tb_pipe_mux_param;

    localparam int L_DEF = 4;
    localparam int L16   = 2;
    localparam int L32   = 3;

    logic         clk;
    logic         reset;
    logic [127:0] in_;
    logic [6:0]   sel;
    logic         in_val;
    logic         in_rdy;
    logic [0:0]   out;
    logic         out_val;
    logic         out_rdy;

    logic [127:0] in16;
    logic [3:0]   sel16;
    logic         val16, rdy16, oval16, ordy16;
    logic [7:0]   out16;

    logic [255:0] in32;
    logic [4:0]   sel32;
    logic         val32, rdy32, oval32, ordy32;
    logic [7:0]   out32;

    pipe_mux_param dut (
        .clk(clk), .reset(reset), .in_(in_), .sel(sel), .in_val(in_val),
        .in_rdy(in_rdy), .out(out), .out_val(out_val), .out_rdy(out_rdy)
    );

    pipe_mux_param #(.p_nbits(8), .p_ninputs(16)) dut16 (
        .clk(clk), .reset(reset), .in_(in16), .sel(sel16), .in_val(val16),
        .in_rdy(rdy16), .out(out16), .out_val(oval16), .out_rdy(ordy16)
    );

    pipe_mux_param #(.p_nbits(8), .p_ninputs(32)) dut32 (
        .clk(clk), .reset(reset), .in_(in32), .sel(sel32), .in_val(val32),
        .in_rdy(rdy32), .out(out32), .out_val(oval32), .out_rdy(ordy32)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_acc   = 0;
    logic       lat_chk = 1'b0;
    logic [0:0] exp_q[$];
    int         acc_q[$];
    logic [0:0] e_val;
    int         a_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (out_val && out_rdy) begin
                check("out_has_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e_val = exp_q.pop_front();
                    a_cyc = acc_q.pop_front();
                    check("out_data", 32'(out), 32'(e_val));
                    if (lat_chk) check("latency", cyc - a_cyc, L_DEF);
                end
            end
            if (in_val && in_rdy) begin
                exp_q.push_back(in_[sel]);
                acc_q.push_back(cyc);
                n_acc++;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [6:0] s, input logic [127:0] d);
        logic ok;
        int   n;
        in_val = 1'b1;
        sel    = s;
        in_    = d;
        n      = 0;
        ok     = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("send_timeout", 32'(ok), 1);
        in_val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int ks[7];
        int c0, acc_bp, guard, start, stale;
        logic fired;
        ks = '{0, 1, 2, 3, 15, 100, 127};

        reset = 1'b0; in_ = '0; sel = '0; in_val = 1'b0; out_rdy = 1'b1;
        in16 = '0; sel16 = '0; val16 = 1'b0; ordy16 = 1'b1;
        in32 = '0; sel32 = '0; val32 = 1'b0; ordy32 = 1'b1;
        for (int i = 0; i < 16; i++) in16[i*8 +: 8] = 8'(i + 'hA0);
        for (int i = 0; i < 32; i++) in32[i*8 +: 8] = 8'(i + 'hA0);

        #1;
        check("rst_out_val", 32'(out_val), 0);
        check("rst_in_rdy", 32'(in_rdy), 0);
        check("rst_out", 32'(out), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_rdy", 32'(in_rdy), 1);
        @(posedge clk);
        #1;

        // one-hot walk, back to back, then zero data
        lat_chk = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 7; i++) send(7'(ks[i]), 128'(1) << ks[i]);
        for (int i = 0; i < 7; i++) send(7'(ks[i]), '0);
        check("throughput_cycles", cyc - c0, 14);
        drain();

        // input change right after acceptance must not leak into the result
        send(7'd5, 128'(1) << 5);
        in_ = '0;
        drain();
        lat_chk = 1'b0;

        // back-pressure: capacity is L transfers
        out_rdy = 1'b0;
        acc_bp  = 0;
        for (int i = 0; i < 6; i++) begin
            in_val = 1'b1;
            sel    = 7'(10 + acc_bp);
            in_    = (acc_bp % 2 == 0) ? (128'(1) << (10 + acc_bp)) : '0;
            @(negedge clk);
            if (in_rdy) acc_bp++;
            @(posedge clk);
            #1;
        end
        check("bp_accepts", acc_bp, L_DEF);
        @(negedge clk);
        check("bp_in_rdy_low", 32'(in_rdy), 0);
        check("bp_out_val", 32'(out_val), 1);
        check("bp_out_hold", 32'(out), 1);
        @(negedge clk);
        check("bp_out_stable", 32'(out), 1);
        @(posedge clk);
        #1 out_rdy = 1'b1;
        #1 check("bp_in_rdy_same_cycle", 32'(in_rdy), 1);
        guard = 0;
        while (acc_bp < 6 && guard < 50) begin
            sel = 7'(10 + acc_bp);
            in_ = (acc_bp % 2 == 0) ? (128'(1) << (10 + acc_bp)) : '0;
            in_val = 1'b1;
            @(negedge clk);
            if (in_rdy) acc_bp++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_val = 1'b0;
        check("bp_refill", acc_bp, 6);
        drain();

        // reset pulse with transfers in flight
        for (int i = 0; i < 3; i++) send(7'(20 + i), 128'(1) << (20 + i));
        @(posedge clk);
        #2;
        check("rst_mid_pre_out_val", 32'(out_val), 1);
        reset = 1'b0;
        #1;
        check("rst_mid_out_val", 32'(out_val), 0);
        check("rst_mid_in_rdy", 32'(in_rdy), 0);
        check("rst_mid_out", 32'(out), 0);
        exp_q.delete();
        acc_q.delete();
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_release_rdy", 32'(in_rdy), 1);
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_val) stale++;
        end
        check("rst_mid_no_stale", stale, 0);
        @(posedge clk);
        #1;

        // W=8 N=16 tree, every select
        for (int s = 0; s < 16; s++) begin
            @(posedge clk);
            #1;
            sel16 = 4'(s);
            val16 = 1'b1;
            @(negedge clk);
            check("p16_rdy", 32'(rdy16), 1);
            @(posedge clk);
            #1 val16 = 1'b0;
            repeat (L16 - 1) @(negedge clk);
            check("p16_early", 32'(oval16), 0);
            @(negedge clk);
            check("p16_val", 32'(oval16), 1);
            check("p16_out", 32'(out16), 32'(s + 'hA0));
        end

        // W=8 N=32 tree (final 2:1 level), every select
        for (int s = 0; s < 32; s++) begin
            @(posedge clk);
            #1;
            sel32 = 5'(s);
            val32 = 1'b1;
            @(negedge clk);
            check("p32_rdy", 32'(rdy32), 1);
            @(posedge clk);
            #1 val32 = 1'b0;
            repeat (L32 - 1) @(negedge clk);
            check("p32_early", 32'(oval32), 0);
            @(negedge clk);
            check("p32_val", 32'(oval32), 1);
            check("p32_out", 32'(out32), 32'(s + 'hA0));
        end
        @(posedge clk);
        #1;

        // random stream against the scoreboard
        start  = n_acc;
        guard  = 0;
        fired  = 1'b0;
        in_val = 1'b0;
        while (n_acc < start + 200 && guard < 5000) begin
            if (fired || !in_val) begin
                in_val = ($urandom_range(0, 3) != 0);
                sel    = 7'($urandom_range(0, 127));
                in_    = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fired = in_val && in_rdy;
            @(posedge clk);
            #1;
            guard++;
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        check("rand_count", n_acc - start, 200);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
